jtag_tap_sampled: RTL
=====================

Name: jtag_tap_sampled

Overview:
- JTAG TAP responder: the target-side end of the tms/tck/trst/tdi/tdo link driven by the simulation JTAG master.
- Oversamples the JTAG pins in the system clock domain and runs the IEEE 1149.1 16-state TAP FSM.
- Implements IR, IDCODE, BYPASS and one USER data register, which exchanges data with core-side logic.
- Used in the simulation top in place of, or alongside, the SoC debug TAP, so the DPI JTAG path can be exercised against a known-good responder.

Parameters:
- IR_W, 5: instruction register width (≥2).
- DR_W, 32: USER data register width (≥2).
- IDCODE_VAL, 32'h249511C3: IDCODE register value; bit 0 must be 1.
- IDCODE_INSTR, 5'b00001: IDCODE opcode; loaded into IR on TAP reset.
- USER_INSTR, 5'b00010: USER opcode.
- All other opcodes, including all-ones, select BYPASS.

Ports:
- clk_i, in, 1: system clock; all logic is on the rising edge.
- rst_i, in, 1: synchronous, active-high reset.
- tck_i, in, 1: JTAG TCK, asynchronous to clk_i.
- tms_i, in, 1: JTAG TMS.
- trstn_i, in, 1: JTAG TRST, active low.
- tdi_i, in, 1: JTAG TDI.
- tdo_o, out, 1: JTAG TDO.
- tdo_oe_o, out, 1: high while in Shift-IR or Shift-DR.
- tap_state_o, out, 4: current TAP state code.
- ir_o, out, IR_W: current instruction.
- user_capture_i, in, DR_W: value loaded into the USER register at Capture-DR.
- user_data_o, out, DR_W: USER register value latched at Update-DR.
- user_update_o, out, 1: one-cycle pulse when user_data_o is updated.

Behaviour:
- Synchronisers:
  - tck_i, tms_i, tdi_i and trstn_i each pass through 2 clk_i flops; tck additionally has a third history flop.
  - tck rise = synced tck 1 and history 0. tck fall = synced tck 0 and history 1.
  - All TAP actions happen in the clk_i cycle after the edge is detected: 3 clk_i cycles after the pin edge.
  - tck high and low phases must each last ≥4 clk_i cycles. Shorter phases are unsupported.
- Reset (rst_i=1):
  - Synchroniser flops cleared to 0. The synced trstn=0 holds the TAP in reset until real values propagate.
  - state = TLR; ir_o = IDCODE_INSTR; shift registers = 0.
  - tdo_o = 0, tdo_oe_o = 0, user_data_o = 0, user_update_o = 0.
- State codes:
  - TLR F, RTI C, SelDR 7, CapDR 6, ShDR 2, Ex1DR 1, PauDR 3, Ex2DR 0, UpdDR 5.
  - SelIR 4, CapIR E, ShIR A, Ex1IR 9, PauIR B, Ex2IR 8, UpdIR D.
- Transitions on tck rise, written as (TMS=0 target / TMS=1 target):
  - TLR: RTI / TLR.
  - RTI: RTI / SelDR.
  - SelDR: CapDR / SelIR.
  - CapDR: ShDR / Ex1DR.
  - ShDR: ShDR / Ex1DR.
  - Ex1DR: PauDR / UpdDR.
  - PauDR: PauDR / Ex2DR.
  - Ex2DR: ShDR / UpdDR.
  - UpdDR: RTI / SelDR.
  - SelIR: CapIR / TLR.
  - The IR column (CapIR through UpdIR) mirrors the DR column.
- Register actions on a tck rise, taken from the state before the transition:
  - CapIR: IR shift register <= {0…0,01}.
  - ShIR: IR shift register shifts right; tdi enters the MSB.
  - UpdIR: ir_o <= IR shift register.
  - TLR: ir_o <= IDCODE_INSTR.
  - CapDR: the selected DR loads IDCODE_VAL, user_capture_i, or 0 for BYPASS.
  - ShDR: the selected DR shifts right; tdi enters its MSB. BYPASS is 1 bit wide.
  - UpdDR with ir_o = USER_INSTR: user_data_o <= USER shift register and user_update_o = 1 for exactly one clk_i cycle.
  - UpdDR with any other instruction: no effect on user_data_o or user_update_o.
- TDO, on tck fall:
  - In ShIR or ShDR: tdo_o <= LSB of the active shift register; tdo_oe_o <= 1.
  - In any other state: tdo_oe_o <= 0; tdo_o holds its value.
  - The first bit out after Capture is the captured LSB.
- Simultaneous events:
  - Synced trstn=0 has priority over any tck edge. It forces TLR, ir_o = IDCODE_INSTR and tdo_oe_o = 0, and suppresses the Update pulse.
  - rst_i has priority over everything.
- Five consecutive tck rises with TMS=1 reach TLR from any state.
- Shift counts longer than the register width pass data through unchanged. No wrap or overflow handling is needed.

Test Plan:
- rst_i for 2 cycles, then trstn=1 → tap_state_o=F, ir_o=00001, tdo_oe_o=0, user_data_o=0, user_update_o=0.
- TMS sequence 0,1,0,0 (TLR→RTI→SelDR→CapDR→ShDR), then 32 shifts of tdi=0 → tdo bits, LSB first, assemble 32'h249511C3; tdo_oe_o=1 only during shifting.
- Enter ShIR and shift 5 bits of 11111 → tdo reads 1,0,0,0,0. After UpdIR, ir_o=11111 (BYPASS). A DR shift of 1,0,1,1 → tdo gives 0,1,0,1 (one-bit delay).
- Load IR=00010 with user_capture_i=32'hDEADBEEF, then shift tdi=32'hA5A55A5A → tdo gives 32'hDEADBEEF. At UpdDR, user_data_o=32'hA5A55A5A and user_update_o is high for exactly one clk_i cycle.
- Halfway through a USER ShDR, apply five TMS=1 rises → path ShDR→Ex1DR→UpdDR→SelDR→SelIR→TLR. One user_update_o pulse occurs at UpdDR; final tap_state_o=F and ir_o=00001.
- Drop trstn low mid-ShDR for 6 cycles → tap_state_o=F within 3 cycles, no user_update_o, tdo_oe_o=0, ir_o=00001.

Source files
------------

// File: rtl/jtag_tap_sampled.sv
// JTAG TAP responder that oversamples the JTAG pins in the clk_i domain and runs
// the 16-state TAP FSM with IR, IDCODE, BYPASS and one USER data register.
module jtag_tap_sampled #(
  parameter int unsigned          IR_W         = 5,
  parameter int unsigned          DR_W         = 32,
  parameter logic [31:0]          IDCODE_VAL   = 32'h249511C3,
  parameter logic [IR_W-1:0]      IDCODE_INSTR = 5'b00001,
  parameter logic [IR_W-1:0]      USER_INSTR   = 5'b00010
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            tck_i,
  input  logic            tms_i,
  input  logic            trstn_i,
  input  logic            tdi_i,
  output logic            tdo_o,
  output logic            tdo_oe_o,
  output logic [3:0]      tap_state_o,
  output logic [IR_W-1:0] ir_o,
  input  logic [DR_W-1:0] user_capture_i,
  output logic [DR_W-1:0] user_data_o,
  output logic            user_update_o
);

  typedef enum logic [3:0] {
    TLR    = 4'hF, RTI    = 4'hC,
    SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR = 4'h2, EX1_DR = 4'h1,
    PAU_DR = 4'h3, EX2_DR = 4'h0, UPD_DR = 4'h5,
    SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR = 4'hA, EX1_IR = 4'h9,
    PAU_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
  } tap_state_e;

  logic [1:0] tck_q, tms_q, tdi_q, trstn_q;
  logic       tck_hist_q;
  logic       tck_rise, tck_fall, tms_s, tdi_s, trstn_s;

  tap_state_e state_q, state_d;

  logic [IR_W-1:0] ir_q, ir_sr_q;
  logic [31:0]     idcode_sr_q;
  logic [DR_W-1:0] user_sr_q, user_data_q;
  logic            bypass_q, tdo_q, tdo_oe_q, user_update_q;

  logic sel_idcode, sel_user, shift_ir, shift_dr, shifting, tdo_bit;

  // Two-flop synchronisers; tck gets an extra history flop for edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tck_q      <= '0;
      tms_q      <= '0;
      tdi_q      <= '0;
      trstn_q    <= '0;
      tck_hist_q <= 1'b0;
    end else begin
      tck_q      <= {tck_q[0], tck_i};
      tms_q      <= {tms_q[0], tms_i};
      tdi_q      <= {tdi_q[0], tdi_i};
      trstn_q    <= {trstn_q[0], trstn_i};
      tck_hist_q <= tck_q[1];
    end
  end

  assign tck_rise = tck_q[1] & ~tck_hist_q;
  assign tck_fall = ~tck_q[1] & tck_hist_q;
  assign tms_s    = tms_q[1];
  assign tdi_s    = tdi_q[1];
  assign trstn_s  = trstn_q[1];

  always_ff @(posedge clk_i) begin
    if (rst_i || !trstn_s) begin
      state_q <= TLR;
    end else if (tck_rise) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TLR:    state_d = tms_s ? TLR    : RTI;
      RTI:    state_d = tms_s ? SEL_DR : RTI;
      SEL_DR: state_d = tms_s ? SEL_IR : CAP_DR;
      CAP_DR: state_d = tms_s ? EX1_DR : SH_DR;
      SH_DR:  state_d = tms_s ? EX1_DR : SH_DR;
      EX1_DR: state_d = tms_s ? UPD_DR : PAU_DR;
      PAU_DR: state_d = tms_s ? EX2_DR : PAU_DR;
      EX2_DR: state_d = tms_s ? UPD_DR : SH_DR;
      UPD_DR: state_d = tms_s ? SEL_DR : RTI;
      SEL_IR: state_d = tms_s ? TLR    : CAP_IR;
      CAP_IR: state_d = tms_s ? EX1_IR : SH_IR;
      SH_IR:  state_d = tms_s ? EX1_IR : SH_IR;
      EX1_IR: state_d = tms_s ? UPD_IR : PAU_IR;
      PAU_IR: state_d = tms_s ? EX2_IR : PAU_IR;
      EX2_IR: state_d = tms_s ? UPD_IR : SH_IR;
      UPD_IR: state_d = tms_s ? SEL_DR : RTI;
      default: state_d = TLR;
    endcase
  end

  // Decode of the current state and instruction; BYPASS is whatever is left.
  always_comb begin
    shift_ir   = (state_q == SH_IR);
    shift_dr   = (state_q == SH_DR);
    shifting   = shift_ir | shift_dr;
    sel_idcode = (ir_q == IDCODE_INSTR);
    sel_user   = (ir_q == USER_INSTR) && !sel_idcode;
    if (shift_ir)        tdo_bit = ir_sr_q[0];
    else if (sel_idcode) tdo_bit = idcode_sr_q[0];
    else if (sel_user)   tdo_bit = user_sr_q[0];
    else                 tdo_bit = bypass_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ir_q          <= IDCODE_INSTR;
      ir_sr_q       <= '0;
      idcode_sr_q   <= '0;
      user_sr_q     <= '0;
      bypass_q      <= 1'b0;
      tdo_q         <= 1'b0;
      tdo_oe_q      <= 1'b0;
      user_data_q   <= '0;
      user_update_q <= 1'b0;
    end else begin
      user_update_q <= 1'b0;
      if (!trstn_s) begin
        ir_q     <= IDCODE_INSTR;
        tdo_oe_q <= 1'b0;
      end else begin
        // Sitting in Test-Logic-Reset keeps IDCODE selected, however TLR was reached.
        if (state_q == TLR) ir_q <= IDCODE_INSTR;
        if (tck_rise) begin
          unique case (state_q)
            CAP_IR: ir_sr_q <= IR_W'(1);
            SH_IR:  ir_sr_q <= {tdi_s, ir_sr_q[IR_W-1:1]};
            UPD_IR: ir_q    <= ir_sr_q;
            CAP_DR: begin
              if (sel_idcode)    idcode_sr_q <= IDCODE_VAL;
              else if (sel_user) user_sr_q   <= user_capture_i;
              else               bypass_q    <= 1'b0;
            end
            SH_DR: begin
              if (sel_idcode)    idcode_sr_q <= {tdi_s, idcode_sr_q[31:1]};
              else if (sel_user) user_sr_q   <= {tdi_s, user_sr_q[DR_W-1:1]};
              else               bypass_q    <= tdi_s;
            end
            UPD_DR: begin
              if (sel_user) begin
                user_data_q   <= user_sr_q;
                user_update_q <= 1'b1;
              end
            end
            default: ;
          endcase
        end else if (tck_fall) begin
          if (shifting) begin
            tdo_q    <= tdo_bit;
            tdo_oe_q <= 1'b1;
          end else begin
            tdo_oe_q <= 1'b0;
          end
        end
      end
    end
  end

  assign tdo_o         = tdo_q;
  assign tdo_oe_o      = tdo_oe_q;
  assign tap_state_o   = state_q;
  assign ir_o          = ir_q;
  assign user_data_o   = user_data_q;
  assign user_update_o = user_update_q;

endmodule
